// File: rtl/floppy_host_seek.sv
// Host-side floppy head-positioning sequencer: SEEK/RECALIBRATE step pulse generation and head tracking.
// Optional index-period measurement is enabled by defining FLOPPY_HOST_INDEX_PERIOD_EN.
module floppy_host_seek #(
  parameter int STEP_PULSE_CYC = 8,
  parameter int STEP_RATE_CYC  = 3000,
  parameter int DIR_SETUP_CYC  = 4,
  parameter int SETTLE_CYC     = 15000,
  parameter int MAX_TRACK      = 79,
  parameter int RECAL_LIMIT    = 85
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [6:0]  cmd_track,
  input  logic [1:0]  cmd_drive,
  input  logic        motor_req,
  output logic        done,
  output logic        err,
  output logic [6:0]  cur_track,
  output logic [3:0]  drive_sel,
  output logic        motor_on,
  output logic        dir_sel,
  output logic        step,
  input  logic        track_0,
  input  logic        index
`ifdef FLOPPY_HOST_INDEX_PERIOD_EN
  ,
  output logic [23:0] index_period,
  output logic        index_valid
`endif
);

  typedef enum logic [2:0] {IDLE, DIR_SETUP, STEP_HI, STEP_LO, SETTLE, DONE} state_t;

  localparam logic [31:0] DIR_LAST    = 32'(DIR_SETUP_CYC - 1);
  localparam logic [31:0] PULSE_LAST  = 32'(STEP_PULSE_CYC - 1);
  localparam logic [31:0] LO_LAST     = 32'(STEP_RATE_CYC - STEP_PULSE_CYC - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [6:0]  MAX_TRK     = 7'(MAX_TRACK);
  localparam logic [15:0] RECAL_LIM   = 16'(RECAL_LIMIT);

  state_t      state, state_nxt;
  logic [31:0] tmr, tmr_nxt;
  logic [6:0]  steps_left, steps_left_nxt;
  logic [15:0] steps_done, steps_done_nxt;
  logic        is_recal, recal_nxt;
  logic [6:0]  cur_nxt;
  logic        dir_nxt, err_nxt;
  logic [3:0]  drive_nxt;
  logic        trk0_p0, trk0_p1;

  function automatic logic [6:0] trk_inc(input logic [6:0] t);
    return (t == 7'd127) ? t : t + 7'd1;
  endfunction

  function automatic logic [6:0] trk_dec(input logic [6:0] t);
    return (t == 7'd0) ? t : t - 7'd1;
  endfunction

  // Stage p0/p1: track_0 synchronizer, plus all sequencer state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tmr        <= '0;
      steps_left <= '0;
      steps_done <= '0;
      is_recal   <= 1'b0;
      cur_track  <= '0;
      dir_sel    <= 1'b0;
      err        <= 1'b0;
      drive_sel  <= '0;
      motor_on   <= 1'b0;
      trk0_p0    <= 1'b0;
      trk0_p1    <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmr        <= tmr_nxt;
      steps_left <= steps_left_nxt;
      steps_done <= steps_done_nxt;
      is_recal   <= recal_nxt;
      cur_track  <= cur_nxt;
      dir_sel    <= dir_nxt;
      err        <= err_nxt;
      drive_sel  <= drive_nxt;
      motor_on   <= motor_req;
      trk0_p0    <= track_0;
      trk0_p1    <= trk0_p0;
    end
  end

  always_comb begin
    state_nxt      = state;
    tmr_nxt        = tmr + 32'd1;
    steps_left_nxt = steps_left;
    steps_done_nxt = steps_done;
    recal_nxt      = is_recal;
    cur_nxt        = cur_track;
    dir_nxt        = dir_sel;
    err_nxt        = err;
    drive_nxt      = drive_sel;
    case (state)
      IDLE: begin
        tmr_nxt = '0;
        if (cmd_valid) begin
          drive_nxt      = 4'b0001 << cmd_drive;
          recal_nxt      = cmd_op;
          steps_done_nxt = '0;
          if (cmd_op) begin
            dir_nxt = 1'b0;
            if (trk0_p1) begin
              cur_nxt   = '0;
              state_nxt = SETTLE;
            end else begin
              state_nxt = DIR_SETUP;
            end
          end else if (cmd_track > MAX_TRK) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else if (cmd_track == cur_track) begin
            err_nxt   = 1'b0;
            state_nxt = DONE;
          end else begin
            dir_nxt        = (cmd_track > cur_track);
            steps_left_nxt = (cmd_track > cur_track) ? cmd_track - cur_track
                                                     : cur_track - cmd_track;
            state_nxt      = DIR_SETUP;
          end
        end
      end
      DIR_SETUP: begin
        if (tmr == DIR_LAST) begin
          tmr_nxt   = '0;
          state_nxt = STEP_HI;
        end
      end
      STEP_HI: begin
        if (tmr == PULSE_LAST) begin
          tmr_nxt        = '0;
          cur_nxt        = dir_sel ? trk_inc(cur_track) : trk_dec(cur_track);
          steps_left_nxt = steps_left - 7'd1;
          steps_done_nxt = steps_done + 16'd1;
          state_nxt      = STEP_LO;
        end
      end
      STEP_LO: begin
        if (tmr == LO_LAST) begin
          tmr_nxt = '0;
          // Recalibrate trusts the sensor over the step count, so check it before the limit
          if (is_recal) begin
            if (trk0_p1) begin
              cur_nxt   = '0;
              state_nxt = SETTLE;
            end else if (steps_done == RECAL_LIM) begin
              err_nxt   = 1'b1;
              state_nxt = DONE;
            end else begin
              state_nxt = STEP_HI;
            end
          end else begin
            state_nxt = (steps_left == 7'd0) ? SETTLE : STEP_HI;
          end
        end
      end
      SETTLE: begin
        if (tmr == SETTLE_LAST) begin
          tmr_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        tmr_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign done      = (state == DONE);
  assign step      = (state == STEP_HI);

`ifdef FLOPPY_HOST_INDEX_PERIOD_EN
  logic        idx_p0, idx_p1, idx_p2;
  logic [23:0] idx_cnt;

  function automatic logic [23:0] cnt_sat_inc(input logic [23:0] c);
    return (c == 24'hFFFFFF) ? c : c + 24'd1;
  endfunction

  // Stage p0..p2: index synchronizer and rising-edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_p0       <= 1'b0;
      idx_p1       <= 1'b0;
      idx_p2       <= 1'b0;
      idx_cnt      <= '0;
      index_period <= '0;
      index_valid  <= 1'b0;
    end else begin
      idx_p0 <= index;
      idx_p1 <= idx_p0;
      idx_p2 <= idx_p1;
      if (!motor_on) begin
        idx_cnt     <= '0;
        index_valid <= 1'b0;
      end else if (idx_p1 && !idx_p2) begin
        index_period <= cnt_sat_inc(idx_cnt);
        idx_cnt      <= '0;
        index_valid  <= 1'b1;
      end else begin
        idx_cnt <= cnt_sat_inc(idx_cnt);
      end
    end
  end
`else
  logic unused_index;
  assign unused_index = index;
`endif

endmodule

// File: tb/tb_floppy_host_seek.sv
// Self-checking bench for floppy_host_seek: vector table, hand-written corner sequences and
// randomized commands scored against a command-level model plus a simple drive/head model.
`timescale 1ns/1ps
module tb_floppy_host_seek;
  localparam int PULSE = 2;
  localparam int RATE  = 6;
  localparam int DSET  = 2;
  localparam int SETL  = 5;
  localparam int MAXT  = 79;
  localparam int RLIM  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [6:0] cmd_track = '0;
  logic [1:0] cmd_drive = '0;
  logic       motor_req = 1'b0;
  logic       done, err;
  logic [6:0] cur_track;
  logic [3:0] drive_sel;
  logic       motor_on, dir_sel, step;
  logic       track_0;
  logic       index = 1'b0;
`ifdef FLOPPY_HOST_INDEX_PERIOD_EN
  logic [23:0] index_period;
  logic        index_valid;
`endif

  always #5 clk = ~clk;

  floppy_host_seek #(
    .STEP_PULSE_CYC(PULSE), .STEP_RATE_CYC(RATE), .DIR_SETUP_CYC(DSET),
    .SETTLE_CYC(SETL), .MAX_TRACK(MAXT), .RECAL_LIMIT(RLIM)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_track(cmd_track), .cmd_drive(cmd_drive),
    .motor_req(motor_req), .done(done), .err(err), .cur_track(cur_track),
    .drive_sel(drive_sel), .motor_on(motor_on), .dir_sel(dir_sel), .step(step),
    .track_0(track_0), .index(index)
`ifdef FLOPPY_HOST_INDEX_PERIOD_EN
    , .index_period(index_period), .index_valid(index_valid)
`endif
  );

  // Drive mechanics: head moves one track per step rising edge, sensor true at track 0
  int   drive_pos = 0;
  logic t0_force  = 1'b0;
  always @(posedge step) begin
    if (dir_sel) drive_pos = (drive_pos < 255) ? drive_pos + 1 : drive_pos;
    else         drive_pos = (drive_pos > 0) ? drive_pos - 1 : 0;
  end
  assign track_0 = (drive_pos == 0) && !t0_force;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Command-level reference: outcome from start position, drive position and sensor override
  task automatic predict(input logic op, input int trk, input int cur, input int dpos,
                         input logic frc, output int pulses, output int e, output int ntrk,
                         output int dir, output int lat);
    dir = 0;
    if (!op) begin
      if (trk > MAXT) begin
        pulses = 0; e = 1; ntrk = cur; lat = 0;
      end else if (trk == cur) begin
        pulses = 0; e = 0; ntrk = cur; lat = 0;
      end else begin
        pulses = (trk > cur) ? trk - cur : cur - trk;
        dir = (trk > cur) ? 1 : 0;
        e = 0; ntrk = trk; lat = DSET + RATE * pulses + SETL;
      end
    end else if (!frc && dpos == 0) begin
      pulses = 0; e = 0; ntrk = 0; lat = SETL;
    end else if (!frc && dpos <= RLIM) begin
      pulses = dpos; e = 0; ntrk = 0; lat = DSET + RATE * dpos + SETL;
    end else begin
      pulses = RLIM; e = 1; ntrk = (cur > RLIM) ? cur - RLIM : 0; lat = DSET + RATE * RLIM;
    end
  endtask

  // Issue one command with cmd_valid held until done, observe the step train, and score it
  task automatic run_and_check(input string tag, input logic op, input logic [6:0] trk,
                               input logic [1:0] drv, input logic frc, input int e_pulses,
                               input int e_err, input int e_trk, input int e_dir, input int e_lat);
    int pulses, lat, bad_timing, bad_dir, first_rise, last_rise, busy_ready, k, g;
    logic prev;
    t0_force = frc;
    repeat (3) @(negedge clk);
    cmd_op = op; cmd_track = trk; cmd_drive = drv; cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    check({tag, " ready_before_cmd"}, int'(cmd_ready), 1);
    @(posedge clk);
    pulses = 0; lat = -1; bad_timing = 0; bad_dir = 0; first_rise = -1; last_rise = -1;
    busy_ready = 0; prev = 1'b0; k = 0;
    while (k < 3000) begin
      @(negedge clk);
      if (cmd_ready) busy_ready++;
      if (step && !prev) begin
        pulses++;
        if (first_rise < 0) first_rise = k;
        else if (k - last_rise != RATE) bad_timing++;
        last_rise = k;
      end
      if (!step && prev && (k - last_rise != PULSE)) bad_timing++;
      if (e_pulses > 0 && dir_sel !== e_dir[0]) bad_dir++;
      prev = step;
      if (done) begin lat = k; break; end
      k++;
    end
    check({tag, " done_latency"}, lat, e_lat);
    check({tag, " pulses"}, pulses, e_pulses);
    check({tag, " err"}, int'(err), e_err);
    check({tag, " cur_track"}, int'(cur_track), e_trk);
    check({tag, " drive_sel"}, int'(drive_sel), 1 << drv);
    check({tag, " ready_while_busy"}, busy_ready, 0);
    if (e_pulses > 0) begin
      check({tag, " step_timing_errs"}, bad_timing, 0);
      check({tag, " dir_errs"}, bad_dir, 0);
      check({tag, " dir_setup_ok"}, int'(first_rise >= DSET), 1);
    end
    cmd_valid = 1'b0;
    t0_force = 1'b0;
    @(negedge clk);
    check({tag, " done_one_cycle"}, int'(done), 0);
  endtask

  typedef struct {
    logic       op;
    logic [6:0] trk;
    logic [1:0] drv;
    logic       frc;
    int         pulses;
    int         e;
    int         ntrk;
    int         dir;
    int         lat;
  } vec_t;

  vec_t vecs[12];
  int   model_cur;

  initial begin
    vecs[0]  = '{1'b0, 7'd5,   2'd1, 1'b0, 5,  0, 5,  1, 37};
    vecs[1]  = '{1'b0, 7'd2,   2'd2, 1'b0, 3,  0, 2,  0, 25};
    vecs[2]  = '{1'b0, 7'd80,  2'd0, 1'b0, 0,  1, 2,  0, 0};
    vecs[3]  = '{1'b0, 7'd2,   2'd3, 1'b0, 0,  0, 2,  0, 0};
    vecs[4]  = '{1'b0, 7'd3,   2'd0, 1'b0, 1,  0, 3,  1, 13};
    vecs[5]  = '{1'b1, 7'd0,   2'd1, 1'b0, 3,  0, 0,  0, 25};
    vecs[6]  = '{1'b1, 7'd0,   2'd2, 1'b0, 0,  0, 0,  0, 5};
    vecs[7]  = '{1'b0, 7'd127, 2'd0, 1'b0, 0,  1, 0,  0, 0};
    vecs[8]  = '{1'b0, 7'd12,  2'd1, 1'b0, 12, 0, 12, 1, 79};
    vecs[9]  = '{1'b1, 7'd0,   2'd3, 1'b1, 10, 1, 2,  0, 62};
    vecs[10] = '{1'b0, 7'd79,  2'd2, 1'b0, 77, 0, 79, 1, 469};
    vecs[11] = '{1'b0, 7'd0,   2'd1, 1'b0, 79, 0, 0,  0, 481};

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst cmd_ready", int'(cmd_ready), 1);
    check("rst done", int'(done), 0);
    check("rst err", int'(err), 0);
    check("rst cur_track", int'(cur_track), 0);
    check("rst drive_sel", int'(drive_sel), 0);
    check("rst motor_on", int'(motor_on), 0);
    check("rst dir_sel", int'(dir_sel), 0);
    check("rst step", int'(step), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    motor_req = 1'b1;
    @(negedge clk);
    check("motor_on follows req", int'(motor_on), 1);
    motor_req = 1'b0;
    @(negedge clk);
    check("motor_on drops", int'(motor_on), 0);

    for (int i = 0; i < 12; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].trk, vecs[i].drv, vecs[i].frc,
                    vecs[i].pulses, vecs[i].e, vecs[i].ntrk, vecs[i].dir, vecs[i].lat);

    // Asynchronous reset while a step pulse is high
    begin
      int g;
      @(negedge clk);
      cmd_op = 1'b0; cmd_track = 7'd20; cmd_drive = 2'd2; cmd_valid = 1'b1;
      g = 0;
      while (!step && g < 200) begin @(negedge clk); g++; end
      check("midstep reached step_hi", int'(step), 1);
      cmd_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      check("midstep rst step", int'(step), 0);
      check("midstep rst cmd_ready", int'(cmd_ready), 1);
      check("midstep rst cur_track", int'(cur_track), 0);
      check("midstep rst drive_sel", int'(drive_sel), 0);
      check("midstep rst dir_sel", int'(dir_sel), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
    end

    model_cur = 0;
    for (int i = 0; i < 30; i++) begin
      logic op, frc;
      int   trk, pulses, e, ntrk, dir, lat;
      op  = ($urandom_range(0, 3) == 0);
      frc = op && ($urandom_range(0, 3) == 0);
      trk = ($urandom_range(0, 5) == 0) ? model_cur : $urandom_range(0, 90);
      predict(op, trk, model_cur, drive_pos, frc, pulses, e, ntrk, dir, lat);
      run_and_check($sformatf("rnd%0d", i), op, 7'(trk), 2'($urandom_range(0, 3)), frc,
                    pulses, e, ntrk, dir, lat);
      model_cur = ntrk;
    end

`ifdef FLOPPY_HOST_INDEX_PERIOD_EN
    motor_req = 1'b1;
    repeat (20) @(negedge clk);
    check("idx valid before edge", int'(index_valid), 0);
    for (int p = 0; p < 2; p++) begin
      index = 1'b1;
      repeat (5) @(negedge clk);
      index = 1'b0;
      repeat (995) @(negedge clk);
    end
    check("idx period", int'(index_period), 1000);
    check("idx valid", int'(index_valid), 1);
    motor_req = 1'b0;
    repeat (3) @(negedge clk);
    check("idx valid after motor off", int'(index_valid), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/floppy_host_seek.md
Name: floppy_host_seek

Overview:
- Host-side head-positioning sequencer for the 34-pin floppy bus. It drives drive_sel, motor_on, dir_sel and step toward a drive (or the Overdrive emulator), and consumes track_0 and index.
- Accepts SEEK and RECALIBRATE commands over a valid/ready handshake. Generates correctly timed step pulse trains and tracks the current head position.
- Sits in host-side test fixtures and controller builds, opposite the drive-side controller circuit.

Parameters:
- STEP_PULSE_CYC, 8, step high time in clk cycles (>=1)
- STEP_RATE_CYC, 3000, step period start-to-start in clk cycles (> STEP_PULSE_CYC)
- DIR_SETUP_CYC, 4, cycles dir_sel is stable before the first step edge (>=1)
- SETTLE_CYC, 15000, head settle time after the last step (>=1)
- MAX_TRACK, 79, highest legal track number (<=127)
- RECAL_LIMIT, 85, maximum outward steps during recalibrate before error

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer idle, command accepted when cmd_valid&cmd_ready
- cmd_op  in  1  0=SEEK, 1=RECALIBRATE
- cmd_track  in  7  SEEK target track
- cmd_drive  in  2  drive number, decoded one-hot onto drive_sel
- motor_req  in  1  motor request, passed to motor_on (registered)
- done  out  1  one-cycle pulse when a command completes
- err  out  1  valid with done; 1=command failed
- cur_track  out  7  current head position register
- drive_sel  out  4  one-hot drive select (active-high logic level)
- motor_on  out  1  motor on
- dir_sel  out  1  1=inward (track increasing), 0=outward
- step  out  1  step pulse (active-high)
- track_0  in  1  track 00 sensor from drive (asynchronous)
- index  in  1  index pulse from drive (asynchronous)

Behaviour:
- Reset values: cmd_ready=1, done=0, err=0, cur_track=0, drive_sel=0000, motor_on=0, dir_sel=0, step=0, FSM=IDLE.
- track_0 and index pass through a 2-FF synchronizer before use. Synchronized values lag the pins by 2 cycles.
- motor_on is registered from motor_req (1-cycle latency) and is independent of the FSM.
- drive_sel is latched one-hot from cmd_drive on accept. It holds until the next accepted command.
- Cycle of accept: cmd_ready drops to 0 on the next edge. One command is in flight at a time; the FSM ignores cmd_valid while busy.
- FSM states: IDLE, DIR_SETUP, STEP_HI, STEP_LO, SETTLE, DONE.
- SEEK accept:
  - cmd_track > MAX_TRACK: go to DONE with err=1; no steps issued, cur_track unchanged.
  - cmd_track == cur_track: go to DONE with err=0, zero steps, no settle.
  - Otherwise: dir_sel = (cmd_track > cur_track); step count = |cmd_track - cur_track| (7-bit unsigned); go to DIR_SETUP.
- RECAL accept:
  - dir_sel=0.
  - If synced track_0=1 at accept: cur_track=0, go to SETTLE.
  - Otherwise go to DIR_SETUP with step count unbounded and a RECAL_LIMIT guard.
- DIR_SETUP: hold DIR_SETUP_CYC cycles, then go to STEP_HI.
- STEP_HI: step=1 for STEP_PULSE_CYC cycles. On exit, cur_track increments (dir_sel=1) or decrements (dir_sel=0).
- STEP_LO: step=0 for STEP_RATE_CYC-STEP_PULSE_CYC cycles. Then:
  - SEEK: when steps remain, return to STEP_HI; otherwise go to SETTLE.
  - RECAL: sample synced track_0 at the end of STEP_LO. If 1: cur_track=0, go to SETTLE. Else if steps issued == RECAL_LIMIT: go to DONE with err=1. Else return to STEP_HI.
- cur_track saturates at 0 on decrement and at 127 on increment (no wrap).
- SETTLE: wait SETTLE_CYC cycles, then go to DONE with err=0.
- DONE: done=1 for exactly one cycle with err valid. Then go to IDLE with cmd_ready=1 on the following cycle. err holds its value until the next done.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous), including step=0. cur_track=0 after reset is a nominal value; software issues RECAL after reset.
- Step pulses never shorten: the minimum high time is STEP_PULSE_CYC and the minimum period is STEP_RATE_CYC.

Optional Feature:
- Macro: FLOPPY_HOST_INDEX_PERIOD_EN
- Defined:
  - Adds outputs index_period[23:0] and index_valid(1).
  - A free-running 24-bit counter restarts on each synced index rising edge. At that edge its previous value +1 loads into index_period, and index_valid is set (sticky).
  - Counter saturates at 24'hFFFFFF.
  - Reset: index_period=0, index_valid=0.
  - Counter runs only while motor_on=1. It clears and index_valid drops when motor_on falls.
- Not defined: ports absent, no counter logic.

Test Plan:
- Bench params: STEP_PULSE_CYC=2, STEP_RATE_CYC=6, DIR_SETUP_CYC=2, SETTLE_CYC=5, RECAL_LIMIT=10.
- Reset mid-step: assert rst low during STEP_HI -> step=0, cmd_ready=1, cur_track=0, drive_sel=0 immediately, before the next clk edge.
- RECAL, drive model asserts track_0 after 3 steps from track 3 -> exactly 3 step pulses with dir_sel=0, each high 2 cycles at period 6. cur_track=0; done with err=0 after SETTLE.
- SEEK to 5 from 0 -> dir_sel=1 at least 2 cycles before the first step; 5 pulses; cur_track=5; done with err=0. Then SEEK to 2 -> 3 pulses with dir_sel=0, cur_track=2.
- SEEK 80 (MAX_TRACK=79) -> no step pulses, done with err=1, cur_track unchanged. SEEK to cur_track -> done within 2 cycles of accept, err=0, zero pulses.
- RECAL with track_0 held 0 -> exactly 10 pulses, then done with err=1. cmd_valid held high throughout is accepted only once per completed command.
- With FLOPPY_HOST_INDEX_PERIOD_EN, motor_req=1, index pulses every 1000 cycles -> index_period=1000 and index_valid=1 after the second edge. Drop motor_req -> index_valid=0.
